// File: rtl/line_arbiter_if.sv
// ---------------------------------------------------------------------------
// line_arbiter_if
// Bundles every signal of the line arbiter: the I-cache miss port, the D-cache
// miss/writeback port and the LLC-side port toward the cacheline adaptor.
//   slave  : the arbiter's view (cache requests and adaptor response in,
//            cache responses and adaptor request out)
//   master : the environment's view (caches + adaptor), directions reversed
// Parameters: LINE_W line width in bits, ADDR_W address width.
// ---------------------------------------------------------------------------
interface line_arbiter_if #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
);
   // I-cache side
   logic [ADDR_W-1:0] i_address;
   logic              i_read;
   logic [LINE_W-1:0] i_line_o;
   logic              i_resp;
   // D-cache side
   logic [ADDR_W-1:0] d_address;
   logic              d_read;
   logic              d_write;
   logic [LINE_W-1:0] d_line_i;
   logic [LINE_W-1:0] d_line_o;
   logic              d_resp;
   // adaptor side
   logic [ADDR_W-1:0] address_o;
   logic              read_o;
   logic              write_o;
   logic [LINE_W-1:0] line_o;
   logic [LINE_W-1:0] line_i;
   logic              resp_i;

   modport slave (
      input  i_address, i_read, d_address, d_read, d_write, d_line_i,
             line_i, resp_i,
      output i_line_o, i_resp, d_line_o, d_resp,
             address_o, read_o, write_o, line_o
   );

   modport master (
      output i_address, i_read, d_address, d_read, d_write, d_line_i,
             line_i, resp_i,
      input  i_line_o, i_resp, d_line_o, d_resp,
             address_o, read_o, write_o, line_o
   );
endinterface

// File: rtl/line_arbiter.sv
// ---------------------------------------------------------------------------
// line_arbiter
// Round-robin arbiter between the I-cache (read-only) and D-cache (read/write)
// line miss ports, feeding the single LLC-side port of the cacheline adaptor.
// The winning request's line-aligned address and write line are registered
// and held until the adaptor answers; returned read lines are captured into
// one buffer that feeds both caches, and a one-cycle resp goes to the winner.
// Ports:
//   clk      clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      line_arbiter_if.slave (cache ports in/out, adaptor port out/in)
// Every output is a flop; there is no combinational input->output path.
// ---------------------------------------------------------------------------
module line_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32,
   parameter int OFFS_W = 5
) (
   input  logic          clk,
   input  logic          reset_n,
   line_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD, WR, RET} state_e;

   state_e            state_q, state_d;
   logic              last_d_q, last_d_d;   // 1: D served last / currently granted
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wline_q, wline_d;
   logic [LINE_W-1:0] rline_q, rline_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic              i_resp_q, i_resp_d;
   logic              d_resp_q, d_resp_d;

   logic              d_req, i_req, pick_d;
   logic [ADDR_W-1:0] i_aligned, d_aligned;

   assign i_aligned = {bus.i_address[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
   assign d_aligned = {bus.d_address[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      addr_d   = addr_q;
      wline_d  = wline_q;
      rline_d  = rline_q;
      read_d   = read_q;
      write_d  = write_q;
      i_resp_d = 1'b0;
      d_resp_d = 1'b0;
      d_req    = bus.d_read | bus.d_write;
      i_req    = bus.i_read;
      // On a tie D wins only if I was served last.
      pick_d   = d_req & (~i_req | ~last_d_q);

      unique case (state_q)
         IDLE: begin
            if (d_req | i_req) begin
               last_d_d = pick_d;
               addr_d   = pick_d ? d_aligned : i_aligned;
               // A D request with both read and write set is treated as a write.
               if (pick_d & bus.d_write) begin
                  wline_d = bus.d_line_i;
                  write_d = 1'b1;
                  state_d = WR;
               end else begin
                  read_d  = 1'b1;
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (bus.resp_i) begin
               read_d   = 1'b0;
               rline_d  = bus.line_i;
               // Responses are launched here so they are visible during RET.
               i_resp_d = ~last_d_q;
               d_resp_d = last_d_q;
               state_d  = RET;
            end
         end
         WR: begin
            if (bus.resp_i) begin
               write_d  = 1'b0;
               i_resp_d = ~last_d_q;
               d_resp_d = last_d_q;
               state_d  = RET;
            end
         end
         RET:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         addr_q   <= '0;
         wline_q  <= '0;
         rline_q  <= '0;
         read_q   <= 1'b0;
         write_q  <= 1'b0;
         i_resp_q <= 1'b0;
         d_resp_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         addr_q   <= addr_d;
         wline_q  <= wline_d;
         rline_q  <= rline_d;
         read_q   <= read_d;
         write_q  <= write_d;
         i_resp_q <= i_resp_d;
         d_resp_q <= d_resp_d;
      end
   end

   assign bus.address_o = addr_q;
   assign bus.read_o    = read_q;
   assign bus.write_o   = write_q;
   assign bus.line_o    = wline_q;
   assign bus.i_line_o  = rline_q;
   assign bus.d_line_o  = rline_q;
   assign bus.i_resp    = i_resp_q;
   assign bus.d_resp    = d_resp_q;

endmodule

// File: tb/tb_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_line_arbiter
// Directed bench for line_arbiter. A transaction-level model tracks the
// outstanding adaptor operation (kind, owner, address, write line), the read
// buffer and the expected response pulse; a compare thread checks every DUT
// output against it on each falling edge. Directed scenarios add literal
// expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_line_arbiter;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int OFFS_W = 5;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   line_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus();

   line_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .OFFS_W(OFFS_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks = 0;
   int failures = 0;

   // ---------------- model ----------------
   // m_rd/m_wr : adaptor operation outstanding; m_own_d : owner (1 = D)
   // m_gap     : the one cycle after a response in which no request is taken
   logic              m_rd, m_wr, m_own_d, m_gap, m_iresp, m_dresp;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_line, m_buf;

   wire want_d = bus.d_read | bus.d_write;
   wire want_i = bus.i_read;
   // Tie: serve the side that was not served last.
   wire win_d  = want_d && !(want_i && m_own_d);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_rd <= 1'b0; m_wr <= 1'b0; m_own_d <= 1'b0; m_gap <= 1'b0;
         m_iresp <= 1'b0; m_dresp <= 1'b0;
         m_addr <= '0; m_line <= '0; m_buf <= '0;
      end else begin
         m_iresp <= 1'b0;
         m_dresp <= 1'b0;
         if (m_rd || m_wr) begin
            if (bus.resp_i) begin
               m_rd  <= 1'b0;
               m_wr  <= 1'b0;
               m_gap <= 1'b1;
               if (m_rd) m_buf <= bus.line_i;
               if (m_own_d) m_dresp <= 1'b1; else m_iresp <= 1'b1;
            end
         end else if (m_gap) begin
            m_gap <= 1'b0;
         end else if (want_d || want_i) begin
            m_own_d <= win_d;
            m_addr  <= (win_d ? bus.d_address : bus.i_address) & ~32'h1F;
            if (win_d && bus.d_write) begin
               m_wr   <= 1'b1;
               m_line <= bus.d_line_i;
            end else begin
               m_rd <= 1'b1;
            end
         end
      end
   end

   // ---------------- check helpers ----------------
   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chka(input string name, input logic [ADDR_W-1:0] act,
                       input logic [ADDR_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic chkw(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chkb("cyc_read_o",  bus.read_o,  m_rd);
      chkb("cyc_write_o", bus.write_o, m_wr);
      chkb("cyc_excl",    bus.read_o & bus.write_o, 1'b0);
      chka("cyc_address", bus.address_o, m_addr);
      chkw("cyc_line_o",  bus.line_o,  m_line);
      chkb("cyc_i_resp",  bus.i_resp,  m_iresp);
      chkb("cyc_d_resp",  bus.d_resp,  m_dresp);
      chkw("cyc_i_line",  bus.i_line_o, m_buf);
      chkw("cyc_d_line",  bus.d_line_o, m_buf);
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_op(input string name);
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.read_o || bus.write_o) begin got = 1; break; end
         tick(1);
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL %s op_timeout actual=none expected=read_o|write_o", name);
      end
   endtask

   task automatic pulse_resp(input logic [LINE_W-1:0] data);
      tick(2);
      bus.resp_i = 1'b1;
      bus.line_i = data;
      tick(1);
      bus.resp_i = 1'b0;
      bus.line_i = ~data;   // buffer must have captured only on the resp edge
   endtask

   task automatic wait_resp(input string name, output bit side_d);
      bit got = 0;
      side_d = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.i_resp || bus.d_resp) begin side_d = bus.d_resp; got = 1; break; end
         tick(1);
      end
      if (!got) begin
         checks++; failures++;
         $display("FAIL %s resp_timeout actual=none expected=resp", name);
      end
   endtask

   // ---------------- directed test ----------------
   logic [LINE_W-1:0] d_aa, d_w2, d_cc, d_w6, d_junk;
   bit side;
   bit ord[4];
   bit exp_ord[4];

   initial begin
      d_aa   = {8{32'hAAAA_AAAA}};
      d_w2   = {4{64'h0123_4567_89AB_CDEF}};
      d_cc   = {8{32'hCCCC_1111}};
      d_w6   = {8{32'h6666_0000}};
      d_junk = {8{32'h5555_5555}};
      exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};

      bus.i_address = '0; bus.i_read = 0;
      bus.d_address = '0; bus.d_read = 0; bus.d_write = 0; bus.d_line_i = '0;
      bus.line_i = '0; bus.resp_i = 0;

      fork
         forever begin
            @(negedge clk);
            compare();
         end
      join_none

      tick(3);
      chkb("rst_read_o", bus.read_o, 1'b0);
      chkb("rst_write_o", bus.write_o, 1'b0);
      chka("rst_address", bus.address_o, 32'h0);
      chkw("rst_line_o", bus.line_o, '0);
      chkw("rst_i_line", bus.i_line_o, '0);
      reset_n = 1'b1;
      tick(2);

      // 1: I-cache read
      bus.i_address = 32'h0000_1234; bus.i_read = 1;
      wait_op("t1");
      chkb("t1_read_o", bus.read_o, 1'b1);
      chka("t1_address", bus.address_o, 32'h0000_1220);
      pulse_resp(d_aa);
      wait_resp("t1", side);
      chkb("t1_side_is_d", side, 1'b0);
      chkw("t1_i_line", bus.i_line_o, d_aa);
      chkb("t1_d_resp", bus.d_resp, 1'b0);
      chkb("t1_read_low", bus.read_o, 1'b0);
      bus.i_read = 0;
      tick(2);

      // 2: D-cache write
      bus.d_address = 32'h8000_0040; bus.d_line_i = d_w2; bus.d_write = 1;
      wait_op("t2");
      chkb("t2_write_o", bus.write_o, 1'b1);
      chkb("t2_read_o", bus.read_o, 1'b0);
      chkw("t2_line_o", bus.line_o, d_w2);
      chka("t2_address", bus.address_o, 32'h8000_0040);
      pulse_resp(d_junk);
      wait_resp("t2", side);
      chkb("t2_side_is_d", side, 1'b1);
      chkw("t2_buf_kept", bus.d_line_o, d_aa);
      tick(1);
      chkb("t2_d_resp_one_cycle", bus.d_resp, 1'b0);
      bus.d_write = 0;
      tick(2);

      // 3: tie from reset, requests held -> D, I, D, I
      reset_n = 1'b0;
      tick(2);
      reset_n = 1'b1;
      bus.i_address = 32'h0000_0100; bus.i_read = 1;
      bus.d_address = 32'h0000_0200; bus.d_read = 1;
      for (int k = 0; k < 4; k++) begin
         wait_op("t3");
         pulse_resp({8{k[7:0], 24'h00_0ABC}});
         wait_resp("t3", side);
         ord[k] = side;
      end
      bus.i_read = 0; bus.d_read = 0;
      for (int k = 0; k < 4; k++) chkb("t3_order", ord[k], exp_ord[k]);
      tick(2);

      // 4: D read+write together -> write
      bus.d_address = 32'h0000_0040; bus.d_line_i = d_cc; bus.d_read = 1; bus.d_write = 1;
      wait_op("t4");
      chkb("t4_write_o", bus.write_o, 1'b1);
      chkb("t4_read_o", bus.read_o, 1'b0);
      pulse_resp(d_junk);
      wait_resp("t4", side);
      chkb("t4_side_is_d", side, 1'b1);
      tick(1);
      chkb("t4_d_resp_one_cycle", bus.d_resp, 1'b0);
      bus.d_read = 0; bus.d_write = 0;
      tick(2);

      // 5: reset in the middle of RD
      bus.i_address = 32'h0000_3000; bus.i_read = 1;
      wait_op("t5");
      #2 reset_n = 1'b0;
      #1;
      chkb("t5_read_o_async", bus.read_o, 1'b0);
      chkb("t5_i_resp_async", bus.i_resp, 1'b0);
      chkb("t5_d_resp_async", bus.d_resp, 1'b0);
      chka("t5_address_async", bus.address_o, 32'h0);
      bus.i_read = 0;
      tick(2);
      reset_n = 1'b1;
      tick(4);
      chkb("t5_no_spurious", bus.i_resp | bus.d_resp, 1'b0);
      bus.i_address = 32'h0000_4444; bus.i_read = 1;
      wait_op("t5b");
      chka("t5b_address", bus.address_o, 32'h0000_4440);
      pulse_resp(d_cc);
      wait_resp("t5b", side);
      chkb("t5b_side_is_d", side, 1'b0);
      chkw("t5b_i_line", bus.i_line_o, d_cc);
      bus.i_read = 0;
      tick(2);

      // 6: stray resp in IDLE, then address change while in WR
      bus.resp_i = 1; bus.line_i = d_junk;
      tick(1);
      bus.resp_i = 0;
      tick(2);
      chkb("t6_stray_i_resp", bus.i_resp, 1'b0);
      chkb("t6_stray_d_resp", bus.d_resp, 1'b0);
      chkw("t6_buf_kept", bus.i_line_o, d_cc);
      bus.d_address = 32'h8000_0080; bus.d_line_i = d_w6; bus.d_write = 1;
      wait_op("t6");
      bus.d_address = 32'h1234_5678;
      tick(2);
      chka("t6_addr_held", bus.address_o, 32'h8000_0080);
      pulse_resp(d_junk);
      wait_resp("t6", side);
      chkb("t6_side_is_d", side, 1'b1);
      bus.d_write = 0;
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
